// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin with bounded lock, legality filter on the
// granted access, and a registered one-cycle response per requester.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_funct3,
  input  logic        p0_lock,
  output logic        p0_ready,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_funct3,
  input  logic        p1_lock,
  output logic        p1_ready,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned     CntW    = $clog2(MAX_LOCK + 1);
  localparam logic [CntW-1:0] MaxLock = CntW'(MAX_LOCK);

  logic            prio_q, prio_d;
  logic            lock_v_q, lock_v_d;
  logic            lock_own_q, lock_own_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            owner_req;

  logic            gnt0, gnt1, gnt_any, gnt_port;
  logic            sel_we, sel_lock;
  logic [31:0]     sel_addr, sel_wdata;
  logic [2:0]      sel_funct3;
  logic            funct3_ok, align_ok, range_ok, legal;
  logic [32:0]     size_m1, last_byte;
  logic [31:0]     load_data;

  logic [1:0]      rvalid_q, err_q;
  logic [31:0]     rdata0_q, rdata1_q;

  // A live lock wins outright; otherwise a lone requester, else the priority pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_v_q && !lock_own_q && p0_req) begin
      gnt0 = 1'b1;
    end else if (lock_v_q && lock_own_q && p1_req) begin
      gnt1 = 1'b1;
    end else if (p0_req && p1_req) begin
      gnt0 = ~prio_q;
      gnt1 = prio_q;
    end else begin
      gnt0 = p0_req;
      gnt1 = p1_req;
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign gnt_port = gnt1;

  always_comb begin
    sel_we     = 1'b0;
    sel_lock   = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_funct3 = '0;
    if (gnt0) begin
      sel_we     = p0_we;
      sel_lock   = p0_lock;
      sel_addr   = p0_addr;
      sel_wdata  = p0_wdata;
      sel_funct3 = p0_funct3;
    end else if (gnt1) begin
      sel_we     = p1_we;
      sel_lock   = p1_lock;
      sel_addr   = p1_addr;
      sel_wdata  = p1_wdata;
      sel_funct3 = p1_funct3;
    end
  end

  always_comb begin
    case (sel_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = ~sel_we;
      default:                funct3_ok = 1'b0;
    endcase
    case (sel_funct3[1:0])
      2'b01: begin
        size_m1  = 33'd1;
        align_ok = ~sel_addr[0];
      end
      2'b10: begin
        size_m1  = 33'd3;
        align_ok = (sel_addr[1:0] == 2'b00);
      end
      default: begin
        size_m1  = 33'd0;
        align_ok = 1'b1;
      end
    endcase
    // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range.
    last_byte = {1'b0, sel_addr} + size_m1;
    range_ok  = (last_byte < 33'(DEPTH));
    legal     = gnt_any & funct3_ok & align_ok & range_ok;
  end

  assign p0_ready   = gnt0;
  assign p1_ready   = gnt1;
  assign mem_addr   = sel_addr;
  assign mem_wdata  = sel_wdata;
  assign mem_funct3 = sel_funct3;
  assign mem_re     = legal & ~sel_we;
  assign mem_we     = legal & sel_we;
  assign load_data  = (legal && !sel_we) ? mem_rdata : '0;

  always_comb begin
    prio_d     = prio_q;
    lock_v_d   = lock_v_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    owner_req  = lock_own_q ? p1_req : p0_req;
    if (lock_v_q && !owner_req) begin
      lock_v_d   = 1'b0;
      lock_cnt_d = '0;
    end
    cnt_inc = lock_cnt_d + CntW'(1);
    if (gnt_any) begin
      prio_d = ~gnt_port;
      if (sel_lock && (cnt_inc < MaxLock)) begin
        lock_v_d   = 1'b1;
        lock_own_d = gnt_port;
        lock_cnt_d = cnt_inc;
      end else begin
        lock_v_d   = 1'b0;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      lock_v_q   <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_v_q   <= lock_v_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= {gnt1, gnt0};
      err_q      <= {gnt1 & ~legal, gnt0 & ~legal};
      rdata0_q   <= gnt0 ? load_data : '0;
      rdata1_q   <= gnt1 ? load_data : '0;
    end
  end

  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a spec-level model predicts grants and responses,
// a separate monitor matches each rvalid against the queued expectation.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH    = 32;
  localparam int unsigned MAX_LOCK = 3;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[2], we[2], lock[2];
  logic [31:0] addr[2], wdata[2];
  logic [2:0]  f3[2];

  logic        p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;
  logic        mem_re, mem_we;

  logic [7:0]  dev_mem[DEPTH] = '{default: 8'h00};
  logic [7:0]  ref_mem[DEPTH] = '{default: 8'h00};
  logic [7:0]  b0, b1, b2, b3;

  rsp_t q0[$], q1[$];
  int   m_prio, m_owner, m_cnt;
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_funct3(f3[0]), .p0_lock(lock[0]), .p0_ready(p0_ready), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_funct3(f3[1]), .p1_lock(lock[1]), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached data memory: combinational, extending read; byte-lane write.
  always_comb begin
    b0 = dev_mem[(int'(mem_addr % DEPTH) + 0) % DEPTH];
    b1 = dev_mem[(int'(mem_addr % DEPTH) + 1) % DEPTH];
    b2 = dev_mem[(int'(mem_addr % DEPTH) + 2) % DEPTH];
    b3 = dev_mem[(int'(mem_addr % DEPTH) + 3) % DEPTH];
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      3'b100:  mem_rdata = {24'h0, b0};
      3'b101:  mem_rdata = {16'h0, b1, b0};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int i = 0; i < 4 && i < (1 << mem_funct3[1:0]); i++)
        dev_mem[(int'(mem_addr % DEPTH) + i) % DEPTH] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit ref_legal(input logic w, input logic [31:0] a, input logic [2:0] f);
    int sz;
    if (w ? !(f inside {3'd0, 3'd1, 3'd2}) : !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      return 1'b0;
    sz = 1 << f[1:0];
    if (a % sz != 0) return 1'b0;
    if (longint'(a) + sz - 1 >= longint'(DEPTH)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
    int     sz;
    longint v;
    sz = 1 << f[1:0];
    v  = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
    if (!f[2] && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  task automatic model_step(output int g);
    bit   ok;
    rsp_t r;
    g = -1;
    if (m_owner >= 0 && req[m_owner]) g = m_owner;
    else if (req[0] && req[1])        g = m_prio;
    else if (req[0])                  g = 0;
    else if (req[1])                  g = 1;
    check("p0_ready", p0_ready, g == 0);
    check("p1_ready", p1_ready, g == 1);
    if (g >= 0) begin
      ok = ref_legal(we[g], addr[g], f3[g]);
      check("mem_re", mem_re, ok && !we[g]);
      check("mem_we", mem_we, ok && we[g]);
      check("mem_addr", mem_addr, addr[g]);
      check("mem_funct3", mem_funct3, f3[g]);
      if (we[g]) check("mem_wdata", mem_wdata, wdata[g]);
      r.due   = cyc + 1;
      r.err   = !ok;
      r.rdata = (ok && !we[g]) ? ref_load(addr[g], f3[g]) : 32'h0;
      if (g == 0) q0.push_back(r);
      else        q1.push_back(r);
      if (ok && we[g])
        for (int i = 0; i < (1 << f3[g][1:0]); i++)
          ref_mem[int'(addr[g]) + i] = wdata[g][8*i +: 8];
    end else begin
      check("idle_mem_en", {mem_re, mem_we}, 2'b00);
      check("idle_mem_addr", mem_addr, 32'h0);
    end
    if (m_owner >= 0 && !req[m_owner]) begin
      m_owner = -1;
      m_cnt   = 0;
    end
    if (g >= 0) begin
      m_prio = 1 - g;
      if (lock[g]) begin
        m_cnt++;
        if (m_cnt >= int'(MAX_LOCK)) begin
          m_owner = -1;
          m_cnt   = 0;
        end else begin
          m_owner = g;
        end
      end else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end
  endtask

  // exp_g: 0/1 = that port must be granted, -1 = no grant, -2 = not checked.
  task automatic run_cycle(input int exp_g, output int g);
    @(negedge clk);
    model_step(g);
    if (exp_g != -2)
      check("grant_order", {p1_ready, p0_ready},
            (exp_g == 0) ? 2'b01 : (exp_g == 1) ? 2'b10 : 2'b00);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, input logic l);
    req[n] = 1'b1; we[n] = w; f3[n] = f; addr[n] = a; wdata[n] = d; lock[n] = l;
  endtask

  task automatic idle_all();
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0; we[n] = 1'b0; f3[n] = '0; addr[n] = '0; wdata[n] = '0; lock[n] = 1'b0;
    end
  endtask

  task automatic flush_model();
    q0.delete();
    q1.delete();
    m_prio  = 0;
    m_owner = -1;
    m_cnt   = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_model();
    idle_all();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_req(input int n);
    if ($urandom_range(0, 3) == 0) begin
      req[n] = 1'b0;
    end else begin
      req[n]   = 1'b1;
      we[n]    = 1'($urandom_range(0, 1));
      f3[n]    = 3'($urandom_range(0, 7));
      addr[n]  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, DEPTH + 3);
      wdata[n] = $urandom;
      lock[n]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic mon_port(input int n, input logic v, input logic e, input logic [31:0] d);
    rsp_t r;
    int   have;
    have = (n == 0) ? q0.size() : q1.size();
    if (v) begin
      if (have == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_rvalid p%0d @cycle %0d: got rvalid=1, expected 0", n, cyc);
      end else begin
        r = (n == 0) ? q0.pop_front() : q1.pop_front();
        check("rsp_cycle", cyc, r.due);
        check("rsp_err", e, r.err);
        check("rsp_rdata", d, r.rdata);
      end
    end else if (have > 0) begin
      r = (n == 0) ? q0[0] : q1[0];
      if (r.due <= cyc) begin
        if (n == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        n_tests++;
        n_fail++;
        $display("FAIL missing_rvalid p%0d @cycle %0d: got rvalid=0, expected 1", n, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_port(0, p0_rvalid, p0_err, p0_rdata);
    mon_port(1, p1_rvalid, p1_err, p1_rdata);
  end

  initial begin
    int g;
    rst_n = 1'b1;
    idle_all();
    flush_model();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
    check("rst_err", {p1_err, p0_err}, 2'b00);
    check("rst_rdata0", p0_rdata, 32'h0);
    check("rst_rdata1", p1_rdata, 32'h0);
    check("rst_mem_en", {mem_re, mem_we}, 2'b00);
    check("rst_ready", {p1_ready, p0_ready}, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single-port word store then loads of the same bytes.
    set_req(0, 1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 1'b0); run_cycle(0, g);
    set_req(0, 1'b0, 3'b010, 32'd8, 32'h0, 1'b0);        run_cycle(0, g);
    set_req(0, 1'b0, 3'b000, 32'd11, 32'h0, 1'b0);       run_cycle(0, g);
    set_req(0, 1'b0, 3'b100, 32'd11, 32'h0, 1'b0);       run_cycle(0, g);
    idle_all(); run_cycle(-1, g);

    // Contention straight after reset alternates 0,1,0,1.
    do_reset();
    set_req(0, 1'b0, 3'b010, 32'd8, 32'h0, 1'b0);
    set_req(1, 1'b0, 3'b010, 32'd4, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(i % 2, g);
    idle_all(); run_cycle(-1, g);

    // Lock burst capped at MAX_LOCK, then an early release.
    do_reset();
    set_req(1, 1'b0, 3'b010, 32'd12, 32'h0, 1'b1); run_cycle(1, g);
    set_req(0, 1'b0, 3'b010, 32'd16, 32'h0, 1'b0);
    run_cycle(1, g); run_cycle(1, g); run_cycle(0, g); run_cycle(1, g);
    lock[1] = 1'b0;
    run_cycle(1, g); run_cycle(0, g);
    idle_all(); run_cycle(-1, g);

    // Illegal and boundary accesses.
    set_req(0, 1'b1, 3'b011, 32'd0, 32'h12345678, 1'b0);  run_cycle(0, g);
    set_req(0, 1'b0, 3'b010, 32'd6, 32'h0, 1'b0);         run_cycle(0, g);
    set_req(0, 1'b0, 3'b001, 32'd31, 32'h0, 1'b0);        run_cycle(0, g);
    set_req(0, 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 1'b0);  run_cycle(0, g);
    set_req(0, 1'b1, 3'b100, 32'd0, 32'h0000005A, 1'b0);  run_cycle(0, g);
    set_req(0, 1'b0, 3'b010, 32'd28, 32'h0, 1'b0);        run_cycle(0, g);
    set_req(0, 1'b1, 3'b001, 32'd30, 32'h0000A5C3, 1'b0); run_cycle(0, g);
    set_req(0, 1'b0, 3'b101, 32'd30, 32'h0, 1'b0);        run_cycle(0, g);
    set_req(0, 1'b0, 3'b000, 32'd31, 32'h0, 1'b0);        run_cycle(0, g);
    idle_all(); run_cycle(-1, g);

    // Reset between acceptance and response drops the response and clears priority.
    set_req(0, 1'b0, 3'b010, 32'd8, 32'h0, 1'b0);
    @(negedge clk);
    model_step(g);
    #1 rst_n = 1'b0;
    flush_model();
    idle_all();
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(0, 1'b0, 3'b010, 32'd8, 32'h0, 1'b0);
    set_req(1, 1'b0, 3'b010, 32'd4, 32'h0, 1'b0);
    run_cycle(0, g);
    req[0] = 1'b0;
    run_cycle(1, g);
    idle_all(); run_cycle(-1, g);

    // Randomized traffic; a port holds its request until granted.
    g = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) if (!req[n] || g == n) rand_req(n);
      run_cycle(-2, g);
    end
    for (int c = 0; c < 20 && (req[0] || req[1]); c++) begin
      for (int n = 0; n < 2; n++) if (g == n) req[n] = 1'b0;
      if (req[0] || req[1]) run_cycle(-2, g);
    end
    idle_all();
    run_cycle(-1, g);
    run_cycle(-1, g);
    check("drain_p0", q0.size(), 32'h0);
    check("drain_p1", q1.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single byte-addressed data memory port between requester 0 (CPU load/store unit) and requester 1 (DMA/debug loader).
- Grants at most one access per cycle, using round-robin priority with an optional bounded lock for bursts.
- Filters illegal, misaligned and out-of-range accesses before they reach the memory, so an illegal store never drives the memory's write port.
- Returns a registered response (read data or write ack) to each requester one cycle after acceptance.

Parameters:
- DEPTH, 32, memory size in bytes; must match the attached data memory.
- MAX_LOCK, 8, maximum consecutive locked grants before priority is forced to the other port (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pN_req  in  1  request valid (N = 0,1; all pN_* ports exist for both requesters)
- pN_we  in  1  1 = store, 0 = load
- pN_addr  in  32  byte address
- pN_wdata  in  32  store data (low bytes used per funct3)
- pN_funct3  in  3  RV32 load/store width code
- pN_lock  in  1  hold grant after this access
- pN_ready  out  1  request accepted this cycle (combinational)
- pN_rvalid  out  1  response valid, one cycle after acceptance
- pN_rdata  out  32  load data, 0 for stores and errors
- pN_err  out  1  access rejected, qualified by pN_rvalid
- mem_addr  out  32  to memory
- mem_wdata  out  32  to memory
- mem_funct3  out  3  to memory
- mem_re  out  1  to memory
- mem_we  out  1  to memory
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (async): prio_ptr=0, lock_owner=none, lock_cnt=0; all pN_rvalid/pN_err=0, pN_rdata=0. Combinational outputs are 0 while no request is present.
- Grant (combinational):
  - If lock_owner=k and pk_req=1, grant k.
  - Else if only one req is high, grant it.
  - Else if both are high, grant prio_ptr.
- pN_ready = grant to N. The requester holds req/addr/data stable until ready.
- Legality of the granted access:
  - Load funct3 must be in {000,001,010,100,101}; store funct3 must be in {000,001,010}.
  - Half-word needs addr[0]=0; word needs addr[1:0]=00.
  - addr+size-1 < DEPTH, compared in 33-bit unsigned arithmetic (no wrap).
- Forwarding: mem_addr, mem_wdata and mem_funct3 come from the granted port (0 when idle). mem_re=legal&!we; mem_we=legal&we. They are never both high. Illegal access: mem_re=mem_we=0.
- Response at the posedge after acceptance:
  - pN_rvalid=1 for exactly one cycle.
  - pN_rdata = mem_rdata captured for a legal load, else 0.
  - pN_err = !legal.
  - The other port's rvalid=0.
- Round-robin: after any accepted access by N, prio_ptr = 1-N. This applies even when the access was illegal.
- Lock:
  - An accepted access with pN_lock=1 sets lock_owner=N and increments lock_cnt.
  - Accepted with lock=0, or pN_req low in any cycle while owner: lock_owner=none, lock_cnt=0.
  - When lock_cnt reaches MAX_LOCK, the lock is released after that access: owner=none, cnt=0, prio_ptr=1-N, so the waiting port wins next if requesting.
- Back-to-back: a new request may be accepted in the same cycle a previous response is valid, giving full throughput of 1 access/cycle.
- Reset mid-access: the in-flight response is dropped (no rvalid after reset). A memory write on the same edge is governed by the memory's own reset.

Test Plan:
- Single-port word store/load: p0 store funct3=010, addr=8, wdata=0xDEADBEEF → p0_ready same cycle, p0_rvalid next cycle err=0. Then p0 load addr=8 → rdata=0xDEADBEEF. Repeat load funct3=000 at addr=11 → 0xFFFFFFDE; funct3=100 → 0x000000DE.
- Contention round-robin: both req held for 4 cycles after reset → grants 0,1,0,1; each rvalid only on the matching port one cycle later.
- Lock with MAX_LOCK=3: p1 lock=1, both requesting continuously → p1 granted 3 cycles, then p0 once. With p1 lock=0 mid-burst, p0 granted next cycle.
- Illegal filtering: store funct3=011; word load addr=6 (misaligned); half load addr=31 with DEPTH=32 (out of range); addr=0xFFFFFFFF byte load → each has mem_we=mem_re=0, rvalid next cycle with err=1, rdata=0.
- Async reset mid-operation: assert rst_n=0 between acceptance and response → no rvalid, prio_ptr back to 0 (both req → p0 wins first).
